// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
//   Shared constants and types for the FIB hash-unit arbiter and related
//   FIB/PIT arbitration logic.
//
//   PREFIX_W / LEN_W / HASH_W : default datapath widths
//   arb_state_t               : arbiter FSM state (IDLE, WAIT, DONE)
//   req_id_t                  : requester identity (insert or lookup path)
// -----------------------------------------------------------------------------
package fib_pkg;

    localparam int unsigned PREFIX_W = 64;
    localparam int unsigned LEN_W    = 6;
    localparam int unsigned HASH_W   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_INS = 1'b0,
        REQ_LKP = 1'b1
    } req_id_t;

endpackage : fib_pkg

// File: rtl/fib_rr_pick.sv
// -----------------------------------------------------------------------------
// fib_rr_pick
//   Combinational 2-way round-robin pick. On a tie the requester that did not
//   win last time is chosen; a lone requester always wins.
//
//   req[1:0]   : request vector, indexed by req_id_t
//   last_owner : requester that won the previous arbitration
//   winner     : selected requester (only meaningful when any is high)
//   any        : at least one request is pending
// -----------------------------------------------------------------------------
module fib_rr_pick
    import fib_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_owner,
    output req_id_t    winner,
    output logic       any
);

    always_comb begin
        any    = req[REQ_INS] | req[REQ_LKP];
        winner = REQ_INS;
        if (req[REQ_INS] && req[REQ_LKP]) begin
            if (last_owner == REQ_INS) begin
                winner = REQ_LKP;
            end else begin
                winner = REQ_INS;
            end
        end else if (req[REQ_LKP]) begin
            winner = REQ_LKP;
        end
    end

endmodule : fib_rr_pick

// File: rtl/fib_hash_arbiter.sv
// -----------------------------------------------------------------------------
// fib_hash_arbiter
//   Shares the FIB's single hash unit between the insert path and the
//   lookup (longest-prefix-match) path. One transaction at a time: pick a
//   winner, present its prefix/len to the hash unit, wait HASH_LAT cycles,
//   capture the hash and pulse the winner's done for one cycle.
//
//   clk, rst                 : clock, synchronous active-high reset
//   ins_req/_prefix/_len     : insert request (held until ins_gnt)
//   ins_gnt, ins_done        : one-cycle accept / result-valid pulses
//   lkp_req/_prefix/_len     : lookup request (held until lkp_gnt)
//   lkp_gnt, lkp_done        : one-cycle accept / result-valid pulses
//   hash_out                 : captured hash, held until the next capture
//   hash_prefix_in/_len_in   : drive the hash unit, stable issue->capture
//   hash_value               : hash unit result
//   busy                     : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module fib_hash_arbiter #(
    parameter int unsigned PREFIX_W = fib_pkg::PREFIX_W,
    parameter int unsigned LEN_W    = fib_pkg::LEN_W,
    parameter int unsigned HASH_W   = fib_pkg::HASH_W,
    parameter int unsigned HASH_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ins_req,
    input  logic [PREFIX_W-1:0] ins_prefix,
    input  logic [LEN_W-1:0]    ins_len,
    output logic                ins_gnt,
    output logic                ins_done,

    input  logic                lkp_req,
    input  logic [PREFIX_W-1:0] lkp_prefix,
    input  logic [LEN_W-1:0]    lkp_len,
    output logic                lkp_gnt,
    output logic                lkp_done,

    output logic [HASH_W-1:0]   hash_out,
    output logic [PREFIX_W-1:0] hash_prefix_in,
    output logic [LEN_W-1:0]    hash_len_in,
    input  logic [HASH_W-1:0]   hash_value,

    output logic                busy
);

    import fib_pkg::*;

    // One extra bit so the post-capture increment (reaching HASH_LAT) fits.
    localparam int unsigned      CNT_W    = $clog2(HASH_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HASH_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t          state_q,      state_d;
    req_id_t             owner_q,      owner_d;
    req_id_t             last_owner_q, last_owner_d;
    logic [CNT_W-1:0]    wait_cnt_q,   wait_cnt_d;
    logic [PREFIX_W-1:0] prefix_q,     prefix_d;
    logic [LEN_W-1:0]    len_q,        len_d;
    logic [HASH_W-1:0]   hash_q,       hash_d;
    logic                ins_gnt_q,    ins_gnt_d;
    logic                lkp_gnt_q,    lkp_gnt_d;
    logic                ins_done_q,   ins_done_d;
    logic                lkp_done_q,   lkp_done_d;

    req_id_t             winner;
    logic                any_req;
    logic [1:0]          req_vec;

    always_comb begin
        req_vec          = '0;
        req_vec[REQ_INS] = ins_req;
        req_vec[REQ_LKP] = lkp_req;
    end

    fib_rr_pick u_pick (
        .req        (req_vec),
        .last_owner (last_owner_q),
        .winner     (winner),
        .any        (any_req)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= REQ_INS;
            last_owner_q <= REQ_LKP;
            wait_cnt_q   <= '0;
            prefix_q     <= '0;
            len_q        <= '0;
            hash_q       <= '0;
            ins_gnt_q    <= 1'b0;
            lkp_gnt_q    <= 1'b0;
            ins_done_q   <= 1'b0;
            lkp_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wait_cnt_q   <= wait_cnt_d;
            prefix_q     <= prefix_d;
            len_q        <= len_d;
            hash_q       <= hash_d;
            ins_gnt_q    <= ins_gnt_d;
            lkp_gnt_q    <= lkp_gnt_d;
            ins_done_q   <= ins_done_d;
            lkp_done_q   <= lkp_done_d;
        end
    end

    // Next-state logic. gnt/done are registered here so each is a clean
    // one-cycle pulse aligned with the first WAIT cycle / the DONE cycle.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wait_cnt_d   = wait_cnt_q;
        prefix_d     = prefix_q;
        len_d        = len_q;
        hash_d       = hash_q;
        ins_gnt_d    = 1'b0;
        lkp_gnt_d    = 1'b0;
        ins_done_d   = 1'b0;
        lkp_done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (winner == REQ_INS) begin
                        prefix_d = ins_prefix;
                        len_d    = ins_len;
                    end else begin
                        prefix_d = lkp_prefix;
                        len_d    = lkp_len;
                    end
                    owner_d      = winner;
                    last_owner_d = winner;
                    wait_cnt_d   = '0;
                    ins_gnt_d    = (winner == REQ_INS);
                    lkp_gnt_d    = (winner == REQ_LKP);
                    state_d      = WAIT;
                end
            end

            WAIT: begin
                wait_cnt_d = wait_cnt_q + CNT_ONE;
                if (wait_cnt_q == CNT_LAST) begin
                    hash_d     = hash_value;
                    ins_done_d = (owner_q == REQ_INS);
                    lkp_done_d = (owner_q == REQ_LKP);
                    state_d    = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ins_gnt        = ins_gnt_q;
        lkp_gnt        = lkp_gnt_q;
        ins_done       = ins_done_q;
        lkp_done       = lkp_done_q;
        hash_out       = hash_q;
        hash_prefix_in = prefix_q;
        hash_len_in    = len_q;
        busy           = (state_q != IDLE);
    end

endmodule : fib_hash_arbiter

// File: tb/tb_fib_hash_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fib_hash_arbiter
//   Directed bench for fib_hash_arbiter. Instance u_dut uses HASH_LAT=1 and a
//   combinational hash model; u_dut3 uses HASH_LAT=3 with a bench-driven
//   hash_value so pre-capture glitches can be injected.
// -----------------------------------------------------------------------------
module tb_fib_hash_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // HASH_LAT = 1 instance signals
    logic        ins_req = 1'b0, lkp_req = 1'b0;
    logic [63:0] ins_prefix = '0, lkp_prefix = '0;
    logic [5:0]  ins_len = '0, lkp_len = '0;
    logic        ins_gnt, ins_done, lkp_gnt, lkp_done, busy;
    logic [9:0]  hash_out, hash_value;
    logic [63:0] hash_prefix_in;
    logic [5:0]  hash_len_in;

    // HASH_LAT = 3 instance signals
    logic        ins_req_b = 1'b0, lkp_req_b = 1'b0;
    logic [63:0] ins_prefix_b = '0, lkp_prefix_b = '0;
    logic [5:0]  ins_len_b = '0, lkp_len_b = '0;
    logic        ins_gnt_b, ins_done_b, lkp_gnt_b, lkp_done_b, busy_b;
    logic [9:0]  hash_out_b;
    logic [9:0]  hv_b = '0;
    logic [63:0] hash_prefix_in_b;
    logic [5:0]  hash_len_in_b;

    function automatic logic [9:0] model_hash(input logic [63:0] p, input logic [5:0] l);
        return p[9:0] ^ p[19:10] ^ p[29:20] ^ p[39:30] ^ p[49:40] ^ p[59:50] ^ {p[63:60], l};
    endfunction

    assign hash_value = model_hash(hash_prefix_in, hash_len_in);

    fib_hash_arbiter #(.PREFIX_W(64), .LEN_W(6), .HASH_W(10), .HASH_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .ins_req(ins_req), .ins_prefix(ins_prefix), .ins_len(ins_len),
        .ins_gnt(ins_gnt), .ins_done(ins_done),
        .lkp_req(lkp_req), .lkp_prefix(lkp_prefix), .lkp_len(lkp_len),
        .lkp_gnt(lkp_gnt), .lkp_done(lkp_done),
        .hash_out(hash_out), .hash_prefix_in(hash_prefix_in), .hash_len_in(hash_len_in),
        .hash_value(hash_value), .busy(busy)
    );

    fib_hash_arbiter #(.PREFIX_W(64), .LEN_W(6), .HASH_W(10), .HASH_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .ins_req(ins_req_b), .ins_prefix(ins_prefix_b), .ins_len(ins_len_b),
        .ins_gnt(ins_gnt_b), .ins_done(ins_done_b),
        .lkp_req(lkp_req_b), .lkp_prefix(lkp_prefix_b), .lkp_len(lkp_len_b),
        .lkp_gnt(lkp_gnt_b), .lkp_done(lkp_done_b),
        .hash_out(hash_out_b), .hash_prefix_in(hash_prefix_in_b), .hash_len_in(hash_len_in_b),
        .hash_value(hv_b), .busy(busy_b)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({ins_gnt, lkp_gnt, ins_done, lkp_done} !== 4'b0000) begin n_bad++; $display("FAIL reset_pulses: got %b want 0000", {ins_gnt, lkp_gnt, ins_done, lkp_done}); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (hash_out !== 10'd0) begin n_bad++; $display("FAIL reset_hash_out: got %h want 000", hash_out); end
        n_cmp++; if ({hash_prefix_in, hash_len_in} !== 70'd0) begin n_bad++; $display("FAIL reset_hash_in: got %h/%h want 0/0", hash_prefix_in, hash_len_in); end
        n_cmp++; if ({busy_b, hash_out_b, ins_gnt_b, lkp_gnt_b} !== 13'd0) begin n_bad++; $display("FAIL reset_dut3: got %b want 0", {busy_b, hash_out_b, ins_gnt_b, lkp_gnt_b}); end
        rst = 1'b0;
    endtask

    task automatic test_single_insert();
        logic [9:0] exp_h;
        exp_h = model_hash(64'hA5A5_0000_0000_0001, 6'd12);
        @(negedge clk);
        ins_prefix = 64'hA5A5_0000_0000_0001; ins_len = 6'd12; ins_req = 1'b1;
        @(negedge clk); // cycle 1
        n_cmp++; if (ins_gnt !== 1'b1) begin n_bad++; $display("FAIL ins_gnt_c1: got %b want 1", ins_gnt); end
        n_cmp++; if (hash_len_in !== 6'd12) begin n_bad++; $display("FAIL ins_len_in_c1: got %0d want 12", hash_len_in); end
        n_cmp++; if (hash_prefix_in !== 64'hA5A5_0000_0000_0001) begin n_bad++; $display("FAIL ins_prefix_in_c1: got %h want a5a5000000000001", hash_prefix_in); end
        n_cmp++; if ({busy, ins_done} !== 2'b10) begin n_bad++; $display("FAIL ins_busy_c1: got %b want 10", {busy, ins_done}); end
        ins_req = 1'b0;
        @(negedge clk); // cycle 2
        n_cmp++; if ({ins_done, ins_gnt} !== 2'b10) begin n_bad++; $display("FAIL ins_done_c2: got %b want 10", {ins_done, ins_gnt}); end
        n_cmp++; if (hash_out !== exp_h) begin n_bad++; $display("FAIL ins_hash_c2: got %h want %h", hash_out, exp_h); end
        @(negedge clk); // cycle 3
        n_cmp++; if ({busy, ins_done} !== 2'b00) begin n_bad++; $display("FAIL ins_idle_c3: got %b want 00", {busy, ins_done}); end
        n_cmp++; if ({lkp_gnt, lkp_done} !== 2'b00) begin n_bad++; $display("FAIL ins_no_lkp: got %b want 00", {lkp_gnt, lkp_done}); end
    endtask

    task automatic test_tie();
        string order;
        order = "";
        @(negedge clk);
        rst = 1'b1;
        ins_prefix = 64'h0000_0000_0000_0333; ins_len = 6'd5;
        lkp_prefix = 64'h0000_0000_0000_0155; lkp_len = 6'd9;
        ins_req = 1'b1; lkp_req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            n_cmp++; if (ins_gnt && lkp_gnt) begin n_bad++; $display("FAIL tie_dual_gnt: got 11 want not both"); end
            if (ins_gnt) order = {order, "I"};
            if (lkp_gnt) order = {order, "L"};
            if (order.len() == 4) begin
                ins_req = 1'b0; lkp_req = 1'b0;
                break;
            end
        end
        n_cmp++; if (order != "ILIL") begin n_bad++; $display("FAIL tie_order: got '%s' want 'ILIL'", order); end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tie_idle: got %b want 0", busy); end
    endtask

    task automatic test_lpm_walk();
        string order;
        int unsigned lk_raised, lk_done;
        order = ""; lk_raised = 1; lk_done = 0;
        @(negedge clk);
        ins_prefix = 64'h0000_0000_0000_0333; ins_len = 6'd5;
        lkp_prefix = 64'h0000_0000_0000_0155; lkp_len = 6'd20; lkp_req = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            n_cmp++; if (ins_done && lkp_done) begin n_bad++; $display("FAIL lpm_dual_done: got 11 want not both"); end
            if (lkp_gnt) begin
                order = {order, "L"};
                lkp_req = 1'b0;
                n_cmp++; if (hash_len_in !== lkp_len) begin n_bad++; $display("FAIL lpm_len_in: got %0d want %0d", hash_len_in, lkp_len); end
            end
            if (ins_gnt) order = {order, "I"};
            if (cyc == 0) ins_req = 1'b1;
            if (order.len() >= 5) ins_req = 1'b0;
            if (ins_done) begin
                n_cmp++; if (hash_out !== model_hash(ins_prefix, ins_len)) begin n_bad++; $display("FAIL lpm_ins_hash: got %h want %h", hash_out, model_hash(ins_prefix, ins_len)); end
            end
            if (lkp_done) begin
                n_cmp++; if (hash_out !== model_hash(lkp_prefix, lkp_len)) begin n_bad++; $display("FAIL lpm_lkp_hash: got %h want %h", hash_out, model_hash(lkp_prefix, lkp_len)); end
                lk_done++;
                if (lk_raised < 3) begin
                    lkp_len = 6'(20 - lk_raised);
                    lkp_req = 1'b1;
                    lk_raised++;
                end
            end
            if (lk_done == 3) break;
        end
        n_cmp++; if (order != "LILIL") begin n_bad++; $display("FAIL lpm_order: got '%s' want 'LILIL'", order); end
        n_cmp++; if (lk_done != 3) begin n_bad++; $display("FAIL lpm_done_count: got %0d want 3", lk_done); end
        ins_req = 1'b0; lkp_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lat3();
        logic [4:0] exp_busy, exp_done;
        exp_busy = 5'b01111; // bit n-1 = cycle n
        exp_done = 5'b01000;
        @(negedge clk);
        lkp_prefix_b = 64'h1234_5678_9ABC_DEF0; lkp_len_b = 6'd33; lkp_req_b = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            n_cmp++; if (busy_b !== exp_busy[cyc-1]) begin n_bad++; $display("FAIL lat3_busy_c%0d: got %b want %b", cyc, busy_b, exp_busy[cyc-1]); end
            n_cmp++; if (lkp_done_b !== exp_done[cyc-1]) begin n_bad++; $display("FAIL lat3_done_c%0d: got %b want %b", cyc, lkp_done_b, exp_done[cyc-1]); end
            n_cmp++; if ({ins_gnt_b, ins_done_b} !== 2'b00) begin n_bad++; $display("FAIL lat3_ins_c%0d: got %b want 00", cyc, {ins_gnt_b, ins_done_b}); end
            if (cyc <= 4) begin
                n_cmp++; if ({hash_prefix_in_b, hash_len_in_b} !== {64'h1234_5678_9ABC_DEF0, 6'd33}) begin n_bad++; $display("FAIL lat3_stable_c%0d: got %h/%0d want 123456789abcdef0/33", cyc, hash_prefix_in_b, hash_len_in_b); end
            end
            case (cyc)
                1: begin
                    n_cmp++; if (lkp_gnt_b !== 1'b1) begin n_bad++; $display("FAIL lat3_gnt: got %b want 1", lkp_gnt_b); end
                    lkp_req_b = 1'b0; hv_b = 10'h2AA;
                end
                2: hv_b = 10'h155;
                3: begin
                    n_cmp++; if (hash_out_b !== 10'h000) begin n_bad++; $display("FAIL lat3_early_capture: got %h want 000", hash_out_b); end
                    hv_b = 10'h3C7;
                end
                4: begin
                    n_cmp++; if (hash_out_b !== 10'h3C7) begin n_bad++; $display("FAIL lat3_hash: got %h want 3c7", hash_out_b); end
                    hv_b = 10'h0F0;
                end
                default: begin
                    n_cmp++; if (hash_out_b !== 10'h3C7) begin n_bad++; $display("FAIL lat3_hash_hold: got %h want 3c7", hash_out_b); end
                end
            endcase
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp_h;
        @(negedge clk);
        ins_prefix = 64'hDEAD_BEEF_0000_1111; ins_len = 6'd7; ins_req = 1'b1;
        @(negedge clk); // WAIT, gnt cycle
        ins_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({busy, ins_done, ins_gnt} !== 3'b000) begin n_bad++; $display("FAIL rstmid_ctrl: got %b want 000", {busy, ins_done, ins_gnt}); end
        n_cmp++; if (hash_out !== 10'd0) begin n_bad++; $display("FAIL rstmid_hash: got %h want 000", hash_out); end
        n_cmp++; if ({hash_prefix_in, hash_len_in} !== 70'd0) begin n_bad++; $display("FAIL rstmid_hash_in: got %h/%h want 0/0", hash_prefix_in, hash_len_in); end
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            n_cmp++; if ({ins_done, lkp_done, busy} !== 3'b000) begin n_bad++; $display("FAIL rstmid_no_done: got %b want 000", {ins_done, lkp_done, busy}); end
        end
        exp_h = model_hash(64'h0F0F_0F0F_0F0F_0F0F, 6'd40);
        ins_prefix = 64'h0F0F_0F0F_0F0F_0F0F; ins_len = 6'd40; ins_req = 1'b1;
        @(negedge clk);
        n_cmp++; if (ins_gnt !== 1'b1) begin n_bad++; $display("FAIL rstmid_fresh_gnt: got %b want 1", ins_gnt); end
        ins_req = 1'b0;
        @(negedge clk);
        n_cmp++; if ({ins_done, hash_out} !== {1'b1, exp_h}) begin n_bad++; $display("FAIL rstmid_fresh_done: got %b/%h want 1/%h", ins_done, hash_out, exp_h); end
        @(negedge clk);
    endtask

    task automatic test_withdraw();
        @(negedge clk);
        ins_prefix = 64'h0000_0000_0000_00FF; ins_len = 6'd3; ins_req = 1'b1;
        @(negedge clk); // WAIT (ins)
        ins_req = 1'b0; lkp_prefix = 64'h0000_0000_0000_0777; lkp_len = 6'd11; lkp_req = 1'b1;
        @(negedge clk); // DONE (ins)
        n_cmp++; if (ins_done !== 1'b1) begin n_bad++; $display("FAIL wd_ins_done: got %b want 1", ins_done); end
        lkp_req = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            n_cmp++; if ({lkp_gnt, lkp_done, busy} !== 3'b000) begin n_bad++; $display("FAIL wd_no_lkp: got %b want 000", {lkp_gnt, lkp_done, busy}); end
        end
    endtask

    initial begin
        test_reset();
        test_single_insert();
        test_tie();
        test_lpm_walk();
        test_lat3();
        test_reset_mid();
        test_withdraw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fib_hash_arbiter

// File: doc/fib_hash_arbiter.md
Name: fib_hash_arbiter

Overview:
Shares the FIB's single hash unit between two requesters: the insert path (data prefix saved into the FIB table) and the lookup path (longest-prefix-match walk on outgoing interests).
- Serialises requests with a 2-way round-robin.
- Drives the hash unit inputs and waits the unit's fixed latency.
- Captures the result and returns it to the winning requester with a one-cycle done pulse.
- Sits between the FIB insert/lookup FSMs and the hash instance.

Parameters:
PREFIX_W, 64, prefix width in bits
LEN_W, 6, prefix length field width
HASH_W, 10, hash index width (1024-entry table)
HASH_LAT, 1, hash unit latency in cycles from stable inputs to valid hash_value; legal range >= 1

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous, active-high reset
ins_req  in  1  insert path requests a hash; held until ins_gnt
ins_prefix  in  PREFIX_W  insert prefix; stable while ins_req high
ins_len  in  LEN_W  insert prefix length
ins_gnt  out  1  one-cycle pulse: insert request accepted
ins_done  out  1  one-cycle pulse: hash_out valid for insert
lkp_req  in  1  lookup path requests a hash; held until lkp_gnt
lkp_prefix  in  PREFIX_W  lookup prefix
lkp_len  in  LEN_W  lookup length (current LPM step)
lkp_gnt  out  1  one-cycle pulse: lookup request accepted
lkp_done  out  1  one-cycle pulse: hash_out valid for lookup
hash_out  out  HASH_W  captured hash; holds until next capture
hash_prefix_in  out  PREFIX_W  to hash unit prefix input
hash_len_in  out  LEN_W  to hash unit length input
hash_value  in  HASH_W  from hash unit
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE and the round-robin pointer last_owner to LKP, so insert wins the first tie.
  - All outputs go to 0: gnt, done, hash_out, hash_prefix_in, hash_len_in, busy.
  - wait_cnt goes to 0.
  - Reset mid-transaction discards the in-flight hash; no done pulse is issued.
- States: IDLE, WAIT, DONE (2-bit encoding).
- IDLE:
  - No request: stay in IDLE; hash_prefix_in and hash_len_in hold their last values.
  - Exactly one request: that requester wins.
  - Both requesting: the requester that is not last_owner wins.
  - At the edge: latch the winner's prefix/len into hash_prefix_in/hash_len_in, set owner and last_owner to the winner, wait_cnt to 0, and move to WAIT.
  - The winner's gnt is registered and is high for exactly the first WAIT cycle.
- WAIT:
  - Requests are ignored; the requester must drop req at the edge ending its gnt cycle.
  - wait_cnt increments each edge.
  - At the edge where wait_cnt == HASH_LAT-1: capture hash_value into hash_out and move to DONE.
- DONE:
  - The owner's done signal is high for this single cycle.
  - Next edge returns to IDLE unconditionally.
- Latency: request sampled at edge E0; done is high in the cycle following edge E0+HASH_LAT. HASH_LAT=1 gives done two cycles after the request edge.
- Throughput: one transaction per HASH_LAT+2 cycles.
- Fairness: a waiting requester loses at most one transaction to the other.
- Withdrawal: a req dropped before it is granted is simply not served; no state change.
- A req still high on return to IDLE is treated as a new request and rearbitrated. A requester that fails to drop req after gnt therefore gets a second transaction; this is legal.
- The hash unit inputs are held stable from the issue edge through capture.
- Simultaneous events:
  - gnt and done never target two requesters in the same cycle.
  - ins_done and lkp_done are mutually exclusive.
- Width rules: no arithmetic on the datapath. wait_cnt is sized clog2(HASH_LAT)+1 and saturates by construction.

Decomposition:
- Package fib_pkg holds:
  - PREFIX_W, LEN_W, HASH_W constants.
  - State encoding localparams IDLE=0, WAIT=1, DONE=2.
  - Requester ID encoding REQ_INS=0, REQ_LKP=1.
- One sub-module, fib_rr_pick: combinational 2-way round-robin pick.
  - Inputs: req[1:0], last_owner.
  - Outputs: winner, any.
  - Reusable for the future PIT/FIB table-port arbiter.
- Everything else lives in fib_hash_arbiter.

Test Plan:
- After reset, ins_req=1 only, ins_prefix=64'hA5A5_0000_0000_0001, ins_len=6'd12, HASH_LAT=1 -> ins_gnt high cycle 1; hash_len_in=12; ins_done high cycle 2 with hash_out equal to model hash; lkp_gnt/lkp_done stay 0.
- ins_req and lkp_req both high from reset -> insert served first; lkp held, granted on the IDLE after ins_done; next tie goes to insert again; grant order I,L,I,L over 4 transactions.
- Lookup LPM walk: lkp_req re-asserted after each lkp_done with len 20,19,18 while ins_req stays high -> order L,I,L,I,L; no requester waits more than one transaction.
- HASH_LAT=3, single lkp request -> busy high 4 cycles; lkp_done exactly in cycle E0+3; hash_prefix_in stable throughout; hash_value changing before capture is ignored.
- rst pulsed in WAIT -> next cycle busy=0, hash_out=0, no done ever issued for the aborted transaction; a fresh ins_req is served normally.
- lkp_req raised then dropped while an insert is in flight -> no lkp_gnt and no lkp_done; state returns to IDLE.
